// File: rtl/hilbert_pkg.sv
// hilbert_pkg: shared types and helpers for the TDM Hilbert transformer.
//   state_t     - controller states
//   taps_legal  - filter length must be 4k+3 (odd-tap antisymmetric form)
//   acc_width   - accumulator width: pre-subtract + coef + log2(M) guard bits
//   sat_round   - round half up, shift right by frac_w, saturate to data_w
package hilbert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    function automatic bit taps_legal(input int taps);
        return (taps >= 3) && ((taps % 4) == 3);
    endfunction

    function automatic int acc_width(input int data_w, input int coef_w, input int m);
        return data_w + 1 + coef_w + ((m > 1) ? $clog2(m) : 0);
    endfunction

    // Works on a sign-extended 64-bit accumulator so one function serves
    // every parameterisation; the caller keeps the low data_w bits.
    function automatic logic [31:0] sat_round(input logic signed [63:0] acc,
                                              input int frac_w,
                                              input int data_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        r  = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r[31:0];
    endfunction

endpackage

// File: rtl/hilbert_mac.sv
// hilbert_mac: pre-subtract / multiply / accumulate datapath.
//   clock, reset - rising-edge clock, async active-high reset
//   clr          - zero the accumulator (new sample starting)
//   en           - add coef * (xa - xb) into the accumulator
//   xa, xb       - signed samples x[n-c+m], x[n-c-m]
//   coef         - signed coefficient for this term
//   acc          - two's-complement accumulator, wide enough never to wrap
module hilbert_mac #(
    parameter int DATA_W = 12,
    parameter int COEF_W = 12,
    parameter int ACC_W  = 27
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] xa,
    input  logic [DATA_W-1:0] xb,
    input  logic [COEF_W-1:0] coef,
    output logic [ACC_W-1:0]  acc
);

    logic signed [DATA_W:0]        diff;
    logic signed [DATA_W+COEF_W:0] prod;

    // One extra bit so x_max - x_min cannot wrap.
    assign diff = $signed({xa[DATA_W-1], xa}) - $signed({xb[DATA_W-1], xb});
    assign prod = diff * $signed(coef);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)    acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/hilbert_fir_tdm.sv
// hilbert_fir_tdm: multi-channel Hilbert transformer, one shared MAC.
//   clock, reset           - rising-edge clock, async active-high reset
//   IN, in_chan, in_valid  - input sample, its channel tag, valid
//   in_ready               - high in IDLE only
//   coef_we/addr/data      - coefficient write; coef[j] = h[c-(2j+1)]
//   coef_ready             - writes honoured (IDLE only)
//   Re, Im, out_chan       - delayed centre sample, Hilbert output, tag
//   out_valid, out_ready   - output handshake
//   chan_err               - one-cycle pulse for an out-of-range in_chan
module hilbert_fir_tdm
    import hilbert_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int COEF_W   = 12,
    parameter int FRAC_W   = 11,
    parameter int TAPS     = 15,
    parameter int CHANNELS = 2,
    localparam int M       = (TAPS + 1) / 4,
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CADDR_W = (M > 1) ? $clog2(M) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DATA_W-1:0]  IN,
    input  logic [CHAN_W-1:0]  in_chan,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               coef_we,
    input  logic [CADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0]  coef_data,
    output logic               coef_ready,
    output logic [DATA_W-1:0]  Re,
    output logic [DATA_W-1:0]  Im,
    output logic [CHAN_W-1:0]  out_chan,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               chan_err
);

    localparam int C     = (TAPS - 1) / 2;
    localparam int ACC_W = acc_width(DATA_W, COEF_W, M);
    localparam logic [CHAN_W:0] NCHAN = (CHAN_W + 1)'(CHANNELS);

    generate
        if (!taps_legal(TAPS)) begin : g_taps_bad
            $error("hilbert_fir_tdm: TAPS must equal 4k+3");
        end
    endgenerate

    state_t state;

    // hist[ch][k] = x[n-k] for that channel; index 0 is the newest sample.
    logic [CHANNELS-1:0][TAPS-1:0][DATA_W-1:0] hist;
    logic [M-1:0][COEF_W-1:0]                  coef;
    logic [CHAN_W-1:0]                         ch;
    logic [CADDR_W-1:0]                        j;

    logic [DATA_W-1:0] xa, xb, xc;
    logic [COEF_W-1:0] cf;
    logic [ACC_W-1:0]  acc;
    logic [31:0]       im_sat;
    logic              chan_ok, mac_clr, mac_en;

    assign in_ready   = (state == ST_IDLE);
    assign coef_ready = (state == ST_IDLE);
    assign chan_ok    = ({1'b0, in_chan} < NCHAN);
    assign mac_clr    = (state == ST_IDLE) && in_valid && chan_ok;
    assign mac_en     = (state == ST_MAC);

    // Operand select for term j of the latched channel. Term j pairs
    // the taps symmetric about the centre at distance m = 2j+1.
    always_comb begin
        xa = '0;
        xb = '0;
        xc = '0;
        cf = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == CHAN_W'(i)) begin
                xc = hist[i][C];
                for (int k = 0; k < M; k++) begin
                    if (j == CADDR_W'(k)) begin
                        xa = hist[i][C - (2 * k + 1)];
                        xb = hist[i][C + (2 * k + 1)];
                    end
                end
            end
        end
        for (int k = 0; k < M; k++) begin
            if (j == CADDR_W'(k)) cf = coef[k];
        end
    end

    hilbert_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clock (clock),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .xa    (xa),
        .xb    (xb),
        .coef  (cf),
        .acc   (acc)
    );

    assign im_sat = sat_round({{(64 - ACC_W){acc[ACC_W-1]}}, acc}, FRAC_W, DATA_W);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            hist      <= '0;
            coef      <= '0;
            ch        <= '0;
            j         <= '0;
            Re        <= '0;
            Im        <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            chan_err  <= 1'b0;
        end else begin
            chan_err <= 1'b0;

            // Coefficient write lands on the same edge as a sample accept;
            // MAC reads it only from the next edge, so the sample sees it.
            if (state == ST_IDLE && coef_we) begin
                for (int k = 0; k < M; k++) begin
                    if (coef_addr == CADDR_W'(k)) coef[k] <= coef_data;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (chan_ok) begin
                            for (int i = 0; i < CHANNELS; i++) begin
                                if (in_chan == CHAN_W'(i))
                                    hist[i] <= {hist[i][TAPS-2:0], IN};
                            end
                            ch    <= in_chan;
                            j     <= '0;
                            state <= ST_MAC;
                        end else begin
                            chan_err <= 1'b1;
                        end
                    end
                end
                ST_MAC: begin
                    if (j == CADDR_W'(M - 1)) state <= ST_ROUND;
                    else                      j     <= j + 1'b1;
                end
                ST_ROUND: begin
                    Re        <= xc;
                    Im        <= im_sat[DATA_W-1:0];
                    out_chan  <= ch;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilbert_fir_tdm.sv
// tb_hilbert_fir_tdm: directed + randomized check of hilbert_fir_tdm against
// a per-channel history / coefficient model computing the antisymmetric FIR
// sum with plain integer arithmetic.
module tb_hilbert_fir_tdm;

    localparam int DW = 12, CW = 12, FW = 11, TP = 15, NCH = 3;
    localparam int M = 4, C = 7, CHW = 2, AW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] IN = '0;
    logic [CHW-1:0] in_chan = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [CW-1:0] coef_data = '0;
    logic          coef_ready;
    logic [DW-1:0] Re, Im;
    logic [CHW-1:0] out_chan;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          chan_err;

    int n_run = 0;
    int n_fail = 0;
    int mh[NCH][TP];
    int mc[M];

    always #5 clock = ~clock;

    hilbert_fir_tdm #(
        .DATA_W(DW), .COEF_W(CW), .FRAC_W(FW), .TAPS(TP), .CHANNELS(NCH)
    ) dut (
        .clock(clock), .reset(reset),
        .IN(IN), .in_chan(in_chan), .in_valid(in_valid), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(coef_ready),
        .Re(Re), .Im(Im), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready), .chan_err(chan_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int want);
        n_run++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, want);
        end
    endtask

    function automatic void mclr();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < TP; k++) mh[c][k] = 0;
        for (int k = 0; k < M; k++) mc[k] = 0;
    endfunction

    function automatic void mpush(input int ch, input int x);
        for (int k = TP - 1; k > 0; k--) mh[ch][k] = mh[ch][k-1];
        mh[ch][0] = x;
    endfunction

    // y = sum_j coef[j]*(x[n-c+m]-x[n-c-m]), scaled by 2^-FW, round half up, clamp.
    function automatic int mim(input int ch);
        longint y = 0;
        for (int j = 0; j < M; j++) begin
            int m = 2 * j + 1;
            y += longint'(mc[j]) * longint'(mh[ch][C-m] - mh[ch][C+m]);
        end
        y = (y + (longint'(1) <<< (FW - 1))) >>> FW;
        if (y > 2047)  y = 2047;
        if (y < -2048) y = -2048;
        return int'(y);
    endfunction

    task automatic do_reset();
        @(negedge clock);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        out_ready = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mclr();
    endtask

    task automatic write_coef(input int a, input int d);
        @(negedge clock);
        chk("coef_rdy", int'(coef_ready), 1);
        coef_we = 1'b1;
        coef_addr = a[AW-1:0];
        coef_data = d[CW-1:0];
        @(posedge clock);
        #1;
        coef_we = 1'b0;
        mc[a] = d;
    endtask

    task automatic wait_ready();
        int w = 0;
        @(negedge clock);
        while (!in_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (w >= 50) chk("rdy_timeout", 0, 1);
    endtask

    // One sample through the block; optional same-edge coefficient write and
    // optional out_ready back-pressure of `hold` cycles.
    task automatic send(input int ch, input int x, input int hold,
                        input bit wr, input int wa, input int wd,
                        output int re_o, output int im_o);
        int lat = 0;
        int ere, eim;
        wait_ready();
        out_ready = (hold == 0);
        IN = x[DW-1:0];
        in_chan = ch[CHW-1:0];
        in_valid = 1'b1;
        coef_we = wr;
        coef_addr = wa[AW-1:0];
        coef_data = wd[CW-1:0];
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        if (wr) mc[wa] = wd;
        mpush(ch, x);
        eim = mim(ch);
        ere = mh[ch][C];
        while (!out_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("latency", lat, M + 1);
        re_o = int'($signed(Re));
        im_o = int'($signed(Im));
        chk("re", re_o, ere);
        chk("im", im_o, eim);
        chk("out_chan", int'(out_chan), ch);
        for (int i = 0; i < hold; i++) begin
            coef_we = (i == 0);
            coef_addr = '0;
            coef_data = 12'd777;
            @(posedge clock);
            #1;
            coef_we = 1'b0;
            chk("hold_ov", int'(out_valid), 1);
            chk("hold_rdy", int'(in_ready), 0);
            chk("hold_crdy", int'(coef_ready), 0);
            chk("hold_re", int'($signed(Re)), ere);
            chk("hold_im", int'($signed(Im)), eim);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("ov_drop", int'(out_valid), 0);
    endtask

    task automatic send_bad(input int x);
        int seen = 0;
        wait_ready();
        IN = x[DW-1:0];
        in_chan = 2'd3;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("chan_err", int'(chan_err), 1);
        chk("bad_rdy", int'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (i == 0) chk("chan_err_clr", int'(chan_err), 0);
            if (out_valid) seen++;
        end
        chk("bad_no_out", seen, 0);
    endtask

    // Impulse 1024 on ch0 then zeros; with coef[0]=1024 expect +512 / -512.
    task automatic t1_seq(input bit ilv, input bit pat);
        int re, im, r1, i1;
        for (int n = 0; n < 16; n++) begin
            send(0, (n == 0) ? 1024 : 0, 0, 1'b0, 0, 0, re, im);
            if (pat) begin
                chk("t1_im", im, (n == 6) ? 512 : ((n == 8) ? -512 : 0));
                chk("t1_re", re, (n == 7) ? 1024 : 0);
            end else begin
                chk("t6_im0", im, 0);
            end
            if (ilv) begin
                send(1, 0, 0, 1'b0, 0, 0, r1, i1);
                chk("t3_ch1_im", i1, 0);
                chk("t3_ch1_re", r1, 0);
            end
        end
    endtask

    initial begin
        int re, im, seen;
        mclr();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_re", int'(Re), 0);
        chk("rst_im", int'(Im), 0);
        chk("rst_chan", int'(out_chan), 0);
        chk("rst_err", int'(chan_err), 0);
        chk("rst_rdy", int'(in_ready), 1);

        // 1: impulse
        write_coef(0, 1024);
        t1_seq(1'b0, 1'b1);

        // 3: interleave + bad channel
        do_reset();
        write_coef(0, 1024);
        t1_seq(1'b1, 1'b1);
        send_bad(1000);
        send(0, 0, 0, 1'b0, 0, 0, re, im);

        // 5: rounding half up
        do_reset();
        write_coef(0, 1);
        send(0, 1024, 0, 1'b0, 0, 0, re, im);
        for (int n = 0; n < 6; n++) send(0, 0, 0, 1'b0, 0, 0, re, im);
        chk("rnd_pos", im, 1);
        do_reset();
        write_coef(0, 1);
        send(0, -1024, 0, 1'b0, 0, 0, re, im);
        for (int n = 0; n < 6; n++) send(0, 0, 0, 1'b0, 0, 0, re, im);
        chk("rnd_neg", im, 0);

        // 4: back-pressure, ignored write, next sample still correct
        do_reset();
        write_coef(0, 1024);
        send(0, 1024, 5, 1'b0, 0, 0, re, im);
        for (int n = 1; n < 9; n++) send(0, 0, 0, 1'b0, 0, 0, re, im);
        chk("bp_im8", im, -512);

        // 2: saturation both ways
        for (int k = 0; k < M; k++) write_coef(k, 2047);
        for (int n = 0; n < 15; n++)
            send(0, (n < 7) ? -2048 : ((n == 7) ? 0 : 2047), 0, 1'b0, 0, 0, re, im);
        chk("sat_hi", im, 2047);
        for (int n = 0; n < 15; n++)
            send(0, (n < 7) ? 2047 : ((n == 7) ? 0 : -2048), 0, 1'b0, 0, 0, re, im);
        chk("sat_lo", im, -2048);

        // 6: reset during the second MAC cycle
        wait_ready();
        IN = 12'd1024;
        in_chan = '0;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_ov", int'(out_valid), 0);
        chk("abort_rdy", int'(in_ready), 1);
        chk("abort_im", int'(Im), 0);
        @(negedge clock);
        reset = 1'b0;
        mclr();
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        chk("abort_no_out", seen, 0);
        t1_seq(1'b0, 1'b0);
        do_reset();
        write_coef(0, 1024);
        t1_seq(1'b0, 1'b1);

        // randomized traffic with random coefficients
        do_reset();
        for (int k = 0; k < M; k++) write_coef(k, int'($urandom_range(0, 4095)) - 2048);
        for (int it = 0; it < 80; it++) begin
            int r = int'($urandom_range(0, 9));
            if (r == 0) begin
                send_bad(int'($urandom_range(0, 4095)));
            end else begin
                int ch = int'($urandom_range(0, NCH - 1));
                int x = (r < 5) ? int'($urandom_range(0, 4095)) - 2048
                                : int'($urandom_range(0, 255)) - 128;
                int hold = (r == 1) ? int'($urandom_range(1, 3)) : 0;
                send(ch, x, hold, (r == 2), int'($urandom_range(0, M - 1)),
                     int'($urandom_range(0, 4095)) - 2048, re, im);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
